// File: rtl/moving_ground_segment.sv
// moving_ground_segment: one scrolling ground rectangle feeding the movingGround mux
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pixelX, pixelY      current VGA pixel
//   startOfFrame        one-cycle pulse per frame; the only moment the position moves
//   start, stop         scroll control pulses (stop wins when both are high)
//   speed               scroll speed in fixed-point units per frame
//   offsetX, offsetY    pixel offset inside the segment, zero outside it
//   drawRequest         pixel lies inside the segment
//   wrapped             one-cycle pulse when the segment re-enters at the right edge
// Build option: define RANDOM_GAP_EN to add an LFSR-driven 0..127 px gap on re-entry.
module moving_ground_segment #(
   parameter logic [10:0] INIT_X   = 11'd0,
   parameter logic [10:0] TOP_Y    = 11'd448,
   parameter logic [10:0] SEG_W    = 11'd320,
   parameter logic [10:0] SEG_H    = 11'd32,
   parameter logic [10:0] SCREEN_W = 11'd640,
   parameter int          FP_MULT  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic        start,
   input  logic        stop,
   input  logic [7:0]  speed,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        drawRequest,
   output logic        wrapped
);
   localparam int SH = $clog2(FP_MULT);
   localparam logic [17:0] INIT_POS = {7'b0, INIT_X} << SH;
   typedef enum logic [1:0] {IDLE, SCROLL, STOPPED} state_t;
   state_t state, state_nxt;
   logic signed [17:0] pos_fp, pos_sub, pos_nxt;
   logic [17:0] reentry;
   logic signed [17-SH:0] left_x, left_sub;
   logic signed [12:0] lx, lx_sub, px, seg_w;
   logic move, wrap, in_x, in_y;
   // position is held in fixed point; the integer pixel X is the floor of posFP/FP_MULT
   assign left_x   = pos_fp[17:SH];
   assign pos_sub  = pos_fp - $signed({10'b0, speed});
   assign left_sub = pos_sub[17:SH];
   assign lx       = 13'(left_x);
   assign lx_sub   = 13'(left_sub);
   assign px       = $signed({2'b0, pixelX});
   assign seg_w    = $signed({2'b0, SEG_W});
`ifdef RANDOM_GAP_EN
   logic [7:0] lfsr, lfsr_step;
   // right-shifting Galois form of x^8+x^6+x^5+x^4+1
   assign lfsr_step = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
   assign reentry   = ({7'b0, SCREEN_W} + {11'b0, lfsr_step[6:0]}) << SH;
   always_ff @(posedge clk)
      if (reset)
         lfsr <= 8'hA5;
      else if (wrap)
         lfsr <= lfsr_step;
`else
   assign reentry = {7'b0, SCREEN_W} << SH;
`endif
   always_comb begin
      state_nxt = stop ? ((state == IDLE) ? IDLE : STOPPED) : (start ? SCROLL : state);
      // the position update sees the state as changed by this cycle's start/stop
      move      = (state_nxt == SCROLL) && startOfFrame;
      wrap      = move && (lx_sub + seg_w <= 13'sd0);
      pos_nxt   = wrap ? $signed(reentry) : (move ? pos_sub : pos_fp);
   end
   // draw test uses the pre-update position of this cycle
   assign in_x = (px >= lx) && (px < lx + seg_w);
   assign in_y = ({1'b0, pixelY} >= {1'b0, TOP_Y}) && ({1'b0, pixelY} < {1'b0, TOP_Y} + {1'b0, SEG_H});
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pos_fp      <= $signed(INIT_POS);
         offsetX     <= 11'd0;
         offsetY     <= 11'd0;
         drawRequest <= 1'b0;
         wrapped     <= 1'b0;
      end else begin
         state       <= state_nxt;
         pos_fp      <= pos_nxt;
         drawRequest <= in_x && in_y;
         offsetX     <= (in_x && in_y) ? pixelX - left_x[10:0] : 11'd0;
         offsetY     <= (in_x && in_y) ? pixelY - TOP_Y : 11'd0;
         wrapped     <= wrap;
      end
   end
endmodule

// File: tb/tb_moving_ground_segment.sv
// tb_moving_ground_segment: directed self-checking bench for moving_ground_segment
module tb_moving_ground_segment;
   logic clk = 1'b0, reset = 1'b1, startOfFrame = 1'b0, start = 1'b0, stop = 1'b0;
   logic [10:0] pixelX = 11'd10, pixelY = 11'd450;
   logic [7:0] speed = 8'd0;
   logic [10:0] offsetX, offsetY;
   logic drawRequest, wrapped, w;
   int checks = 0, errors = 0;
`ifdef RANDOM_GAP_EN
   localparam int G1 = 106, G2 = 117;
`else
   localparam int G1 = 0, G2 = 0;
`endif
   moving_ground_segment dut (
      .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
      .startOfFrame(startOfFrame), .start(start), .stop(stop), .speed(speed),
      .offsetX(offsetX), .offsetY(offsetY), .drawRequest(drawRequest), .wrapped(wrapped)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic pix(input string tag, input int x, input int y, input int dr, input int ox, input int oy);
      @(negedge clk);
      pixelX = 11'(x);
      pixelY = 11'(y);
      @(negedge clk);
      check({tag, ".dr"}, int'(drawRequest), dr);
      check({tag, ".ox"}, int'(offsetX), ox);
      check({tag, ".oy"}, int'(offsetY), oy);
   endtask
   task automatic frame(input int spd, output logic wr);
      @(negedge clk);
      speed = 8'(spd);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      wr = wrapped;
   endtask
   task automatic pulse(input logic sa, input logic so);
      @(negedge clk);
      start = sa;
      stop = so;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
   endtask
   task automatic hold_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      pixelX = 11'd10;
      pixelY = 11'd450;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({tag, ".dr"}, int'(drawRequest), 0);
         check({tag, ".ox"}, int'(offsetX), 0);
         check({tag, ".oy"}, int'(offsetY), 0);
         check({tag, ".wr"}, int'(wrapped), 0);
      end
      reset = 1'b0;
   endtask
   initial begin
      int n, n_exp;
      hold_reset("rst0");
      pix("idle_in", 10, 450, 1, 10, 2);
      pix("idle_above", 10, 447, 0, 0, 0);
      pix("corner", 319, 479, 1, 319, 31);
      pix("right_edge", 320, 450, 0, 0, 0);
      pix("below", 10, 480, 0, 0, 0);
      speed = 8'd128;
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         frame(128, w);
         check("no_wrap5", int'(w), 0);
      end
      pix("neg10", 0, 460, 1, 10, 12);
      pix("neg10_last", 309, 460, 1, 319, 12);
      pix("neg10_out", 310, 460, 0, 0, 0);
      frame(0, w);
      pix("speed0", 0, 460, 1, 10, 12);
      for (int i = 0; i < 77; i++)
         frame(255, w);
      frame(141, w);
      check("no_wrap_319", int'(w), 0);
      pix("at_m319", 0, 460, 1, 319, 12);
      pix("at_m319_out", 1, 460, 0, 0, 0);
      frame(64, w);
      check("wrap1", int'(w), 1);
      @(negedge clk);
      check("wrap1_pulse", int'(wrapped), 0);
      pix("re_before", 639 + G1, 460, 0, 0, 0);
      pix("re_at", 640 + G1, 460, 1, 0, 12);
      pix("re_next", 641 + G1, 460, 1, 1, 12);
      pulse(1'b0, 1'b1);
      frame(64, w);
      frame(64, w);
      pix("stopped", 640 + G1, 460, 1, 0, 12);
      @(negedge clk);
      start = 1'b1;
      startOfFrame = 1'b1;
      speed = 8'd64;
      @(negedge clk);
      start = 1'b0;
      startOfFrame = 1'b0;
      pix("start_sof", 639 + G1, 460, 1, 0, 12);
      n_exp = ((639 + G1) * 64 + 20417 + 254) / 255;
      n = 0;
      w = 1'b0;
      while (!w && n < 300) begin
         frame(255, w);
         n++;
      end
      check("wrap2_frames", n, n_exp);
      pix("re2_at", 640 + G2, 460, 1, 0, 12);
      pix("re2_before", 639 + G2, 460, 0, 0, 0);
      hold_reset("rst_mid");
      pix("after_rst", 10, 450, 1, 10, 2);
      pulse(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         frame(64, w);
         check("idle_wr", int'(w), 0);
      end
      pix("idle_hold", 10, 450, 1, 10, 2);
      pulse(1'b1, 1'b0);
      frame(64, w);
      pix("m1", 0, 450, 1, 1, 2);
      pix("m1_last", 318, 450, 1, 319, 2);
      pix("m1_out", 319, 450, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
